// File: rtl/throw_scheduler.sv
// Siteswap juggling scheduler: one registered throw pulse per beat in RUN, one cycle after new_beat.
// Optional macro THROW_SCHED_CHECK_EN enables the ERROR state on collision, dropped ball or missing ball.
module throw_scheduler #(
  parameter int MAX_LEN = 7
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 new_beat,
  input  logic [3*MAX_LEN-1:0] pattern_in,
  input  logic [2:0]           pattern_length,
  input  logic [2:0]           num_balls_in,
  input  logic                 pattern_valid_in,
  input  logic                 stop_in,
  output logic                 throw_valid_out,
  output logic [2:0]           throw_ball_out,
  output logic [2:0]           throw_height_out,
  output logic                 throw_hand_out,
  output logic                 running_out,
  output logic                 error_out
);

  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

  state_t     state_q, state_d;
  logic [2:0] pattern_q [MAX_LEN];
  logic [2:0] pattern_d [MAX_LEN];
  logic [2:0] len_q, len_d, nballs_q, nballs_d;
  logic [2:0] t_q, t_d, idx_q, idx_d, fresh_q, fresh_d;
  logic       hand_q, hand_d;
  logic [7:0] slot_vld_q, slot_vld_d;
  logic [2:0] slot_ball_q [8];
  logic [2:0] slot_ball_d [8];
  logic       vld_q, vld_d, hand_out_q, hand_out_d;
  logic [2:0] ball_q, ball_d, height_q, height_d;

  logic [2:0] h, tgt;
  logic       occ, fault;

  always_comb begin
    h = 3'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == 3'(i)) h = pattern_q[i];
    end
  end

  assign tgt = t_q + h;
  assign occ = slot_vld_q[t_q];

`ifdef THROW_SCHED_CHECK_EN
  assign fault = (occ && (h == 3'd0 || slot_vld_q[tgt])) ||
                 (!occ && h != 3'd0 && (fresh_q >= nballs_q || slot_vld_q[tgt]));
  assign error_out = (state_q == ERROR) && !rst_in;
`else
  assign fault     = 1'b0;
  assign error_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    nballs_d    = nballs_q;
    t_d         = t_q;
    idx_d       = idx_q;
    fresh_d     = fresh_q;
    hand_d      = hand_q;
    slot_vld_d  = slot_vld_q;
    slot_ball_d = slot_ball_q;
    vld_d       = 1'b0;
    ball_d      = ball_q;
    height_d    = height_q;
    hand_out_d  = hand_out_q;
    case (state_q)
      IDLE: begin
        if (pattern_valid_in && pattern_length != 3'd0) begin
          state_d = RUN;
          for (int i = 0; i < MAX_LEN; i++) pattern_d[i] = pattern_in[3*i +: 3];
          len_d      = pattern_length;
          nballs_d   = num_balls_in;
          slot_vld_d = 8'd0;
          for (int k = 0; k < 8; k++) slot_ball_d[k] = 3'd0;
          t_d        = 3'd0;
          idx_d      = 3'd0;
          fresh_d    = 3'd0;
          hand_d     = 1'b0;
        end
      end
      RUN: begin
        if (stop_in) begin
          state_d = IDLE;
        end else if (new_beat) begin
          if (fault) begin
            state_d = ERROR;
          end else begin
            vld_d      = 1'b1;
            height_d   = h;
            ball_d     = 3'd0;
            hand_out_d = hand_q;
            // Without checking, a held ball with h=0 is dropped and a full target is overwritten.
            if (occ) begin
              ball_d          = slot_ball_q[t_q];
              slot_vld_d[t_q] = 1'b0;
              if (h != 3'd0) begin
                slot_vld_d[tgt]  = 1'b1;
                slot_ball_d[tgt] = slot_ball_q[t_q];
              end
            end else if (h != 3'd0 && fresh_q < nballs_q) begin
              ball_d           = fresh_q;
              slot_vld_d[tgt]  = 1'b1;
              slot_ball_d[tgt] = fresh_q;
              fresh_d          = fresh_q + 3'd1;
            end
            t_d    = t_q + 3'd1;
            idx_d  = (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
            hand_d = ~hand_q;
          end
        end
      end
      ERROR: begin
        if (stop_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pattern_q   <= '{default: 3'd0};
      len_q       <= 3'd0;
      nballs_q    <= 3'd0;
      t_q         <= 3'd0;
      idx_q       <= 3'd0;
      fresh_q     <= 3'd0;
      hand_q      <= 1'b0;
      slot_vld_q  <= 8'd0;
      slot_ball_q <= '{default: 3'd0};
      vld_q       <= 1'b0;
      ball_q      <= 3'd0;
      height_q    <= 3'd0;
      hand_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      nballs_q    <= nballs_d;
      t_q         <= t_d;
      idx_q       <= idx_d;
      fresh_q     <= fresh_d;
      hand_q      <= hand_d;
      slot_vld_q  <= slot_vld_d;
      slot_ball_q <= slot_ball_d;
      vld_q       <= vld_d;
      ball_q      <= ball_d;
      height_q    <= height_d;
      hand_out_q  <= hand_out_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the first edge.
  assign throw_valid_out  = vld_q && !rst_in;
  assign throw_ball_out   = rst_in ? 3'd0 : ball_q;
  assign throw_height_out = rst_in ? 3'd0 : height_q;
  assign throw_hand_out   = hand_out_q && !rst_in;
  assign running_out      = (state_q == RUN) && !rst_in;

endmodule

// File: tb/tb_throw_scheduler.sv
// Directed self-checking bench for throw_scheduler; covers both builds of THROW_SCHED_CHECK_EN.
module tb_throw_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        new_beat = 1'b0;
  logic [20:0] pattern_in = '0;
  logic [2:0]  pattern_length = 3'd0;
  logic [2:0]  num_balls_in = 3'd0;
  logic        pattern_valid_in = 1'b0;
  logic        stop_in = 1'b0;
  logic        throw_valid_out;
  logic [2:0]  throw_ball_out;
  logic [2:0]  throw_height_out;
  logic        throw_hand_out;
  logic        running_out;
  logic        error_out;

  int checks = 0;
  int fails  = 0;

  throw_scheduler #(.MAX_LEN(7)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_beat(new_beat), .pattern_in(pattern_in),
    .pattern_length(pattern_length), .num_balls_in(num_balls_in),
    .pattern_valid_in(pattern_valid_in), .stop_in(stop_in),
    .throw_valid_out(throw_valid_out), .throw_ball_out(throw_ball_out),
    .throw_height_out(throw_height_out), .throw_hand_out(throw_hand_out),
    .running_out(running_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  // {valid, ball, height, hand, running, error}
  function automatic logic [9:0] outs();
    return {throw_valid_out, throw_ball_out, throw_height_out, throw_hand_out, running_out, error_out};
  endfunction

  task automatic load(input logic [20:0] pat, input logic [2:0] len, input logic [2:0] nb);
    @(negedge clk_in);
    pattern_in = pat; pattern_length = len; num_balls_in = nb; pattern_valid_in = 1'b1;
    @(negedge clk_in);
    pattern_valid_in = 1'b0;
  endtask

  task automatic do_beat();
    @(negedge clk_in); new_beat = 1'b1;
    @(negedge clk_in); new_beat = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk_in); stop_in = 1'b1;
    @(negedge clk_in); stop_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    checks++;
    if (outs() !== 10'd0) begin
      fails++; $display("FAIL reset_outputs: got %b expected %b", outs(), 10'd0);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (outs() !== 10'd0) begin
      fails++; $display("FAIL reset_release_idle: got %b expected %b", outs(), 10'd0);
    end
  endtask

  task automatic test_cascade3();
    load(21'd3, 3'd1, 3'd3);
    checks++;
    if (running_out !== 1'b1) begin
      fails++; $display("FAIL cascade_running: got %b expected 1", running_out);
    end
    for (int i = 0; i < 6; i++) begin
      do_beat();
      checks++;
      if (outs() !== {1'b1, 3'(i % 3), 3'd3, 1'(i % 2), 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL cascade_beat%0d: got %b expected %b", i, outs(), {1'b1, 3'(i % 3), 3'd3, 1'(i % 2), 1'b1, 1'b0});
      end
    end
    @(negedge clk_in);
    checks++;
    if (throw_valid_out !== 1'b0) begin
      fails++; $display("FAIL cascade_single_pulse: got %b expected 0", throw_valid_out);
    end
    do_stop();
    checks++;
    if (running_out !== 1'b0) begin
      fails++; $display("FAIL cascade_stop: got %b expected 0", running_out);
    end
  endtask

  task automatic test_pattern_501();
    logic [2:0] eb [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [2:0] eh [9] = '{3'd5, 3'd0, 3'd1, 3'd5, 3'd0, 3'd1, 3'd5, 3'd0, 3'd1};
    load({12'd0, 3'd1, 3'd0, 3'd5}, 3'd3, 3'd2);
    for (int i = 0; i < 9; i++) begin
      do_beat();
      checks++;
      if (outs() !== {1'b1, eb[i], eh[i], 1'(i % 2), 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL p501_beat%0d: got %b expected %b", i, outs(), {1'b1, eb[i], eh[i], 1'(i % 2), 1'b1, 1'b0});
      end
    end
    do_stop();
  endtask

  task automatic test_collision();
    load({15'd0, 3'd3, 3'd4}, 3'd2, 3'd3);
    do_beat();
    checks++;
    if (outs() !== {1'b1, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL coll_beat0: got %b expected %b", outs(), {1'b1, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0});
    end
`ifdef THROW_SCHED_CHECK_EN
    do_beat();
    checks++;
    if (outs() !== {1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL coll_error: got %b expected %b", outs(), {1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1});
    end
    do_beat();
    checks++;
    if (throw_valid_out !== 1'b0 || error_out !== 1'b1) begin
      fails++; $display("FAIL coll_beat_in_error: got valid %b error %b expected 0 1", throw_valid_out, error_out);
    end
    do_stop();
    checks++;
    if (running_out !== 1'b0 || error_out !== 1'b0) begin
      fails++; $display("FAIL coll_stop_idle: got run %b error %b expected 0 0", running_out, error_out);
    end
`else
    begin
      logic [2:0] eb [4] = '{3'd1, 3'd2, 3'd0, 3'd1};
      logic [2:0] eh [4] = '{3'd3, 3'd4, 3'd3, 3'd4};
      for (int i = 0; i < 4; i++) begin
        do_beat();
        checks++;
        if (outs() !== {1'b1, eb[i], eh[i], 1'((i + 1) % 2), 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL overwrite_beat%0d: got %b expected %b", i + 1, outs(), {1'b1, eb[i], eh[i], 1'((i + 1) % 2), 1'b1, 1'b0});
        end
      end
    end
    do_stop();
`endif
  endtask

  task automatic test_stop_with_beat();
    logic [2:0] eb [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd1};
    logic [2:0] eh [6] = '{3'd4, 3'd4, 3'd1, 3'd4, 3'd4, 3'd1};
    load(21'd3, 3'd1, 3'd3);
    repeat (4) do_beat();
    @(negedge clk_in); new_beat = 1'b1; stop_in = 1'b1;
    @(negedge clk_in); new_beat = 1'b0; stop_in = 1'b0;
    checks++;
    if (throw_valid_out !== 1'b0 || running_out !== 1'b0) begin
      fails++; $display("FAIL stop_wins: got valid %b run %b expected 0 0", throw_valid_out, running_out);
    end
    do_beat();
    checks++;
    if (throw_valid_out !== 1'b0) begin
      fails++; $display("FAIL idle_beat: got %b expected 0", throw_valid_out);
    end
    load({12'd0, 3'd1, 3'd4, 3'd4}, 3'd3, 3'd3);
    for (int i = 0; i < 6; i++) begin
      do_beat();
      checks++;
      if (outs() !== {1'b1, eb[i], eh[i], 1'(i % 2), 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reload_beat%0d: got %b expected %b", i, outs(), {1'b1, eb[i], eh[i], 1'(i % 2), 1'b1, 1'b0});
      end
    end
    do_stop();
  endtask

  task automatic test_reset_mid_run();
    load(21'd3, 3'd1, 3'd3);
    repeat (3) do_beat();
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (outs() !== 10'd0) begin
      fails++; $display("FAIL midrun_reset: got %b expected %b", outs(), 10'd0);
    end
    rst_in = 1'b0;
    do_beat();
    checks++;
    if (throw_valid_out !== 1'b0 || running_out !== 1'b0) begin
      fails++; $display("FAIL post_reset_beat: got valid %b run %b expected 0 0", throw_valid_out, running_out);
    end
  endtask

  task automatic test_pattern_hold();
    load(21'd3, 3'd1, 3'd3);
    repeat (3) do_beat();
    @(negedge clk_in);
    pattern_in = 21'd1; num_balls_in = 3'd1; pattern_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_beat();
      checks++;
      if (outs() !== {1'b1, 3'(i), 3'd3, 1'((i + 1) % 2), 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL hold_beat%0d: got %b expected %b", i + 3, outs(), {1'b1, 3'(i), 3'd3, 1'((i + 1) % 2), 1'b1, 1'b0});
      end
    end
    pattern_valid_in = 1'b0;
    do_stop();
  endtask

  task automatic test_back_to_back();
    load(21'd3, 3'd1, 3'd3);
    @(negedge clk_in); new_beat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (i == 2) new_beat = 1'b0;
      checks++;
      if (outs() !== {1'b1, 3'(i), 3'd3, 1'(i % 2), 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL b2b_beat%0d: got %b expected %b", i, outs(), {1'b1, 3'(i), 3'd3, 1'(i % 2), 1'b1, 1'b0});
      end
    end
    @(negedge clk_in);
    checks++;
    if (throw_valid_out !== 1'b0) begin
      fails++; $display("FAIL b2b_end: got %b expected 0", throw_valid_out);
    end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_cascade3();
    test_pattern_501();
    test_collision();
    test_stop_with_beat();
    test_reset_mid_run();
    test_pattern_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/throw_scheduler.md
THROW_SCHEDULER -- requirements
Module: throw_scheduler

Interface
REQ-001 The module SHALL have parameter MAX_LEN, default 7, the number of pattern entries held.
REQ-002 The module SHALL have port clk_in, input, 1, the single system clock.
REQ-003 The module SHALL have port rst_in, input, 1, a synchronous active-high reset.
REQ-004 The module SHALL have port new_beat, input, 1, a one-cycle beat strobe.
REQ-005 The module SHALL have port pattern_in, input, 3 x MAX_LEN, the siteswap throw heights, entry 0 first.
REQ-006 The module SHALL have port pattern_length, input, 3, the number of active entries (1..MAX_LEN).
REQ-007 The module SHALL have port num_balls_in, input, 3, the ball count for the pattern.
REQ-008 The module SHALL have port pattern_valid_in, input, 1, which qualifies the pattern inputs.
REQ-009 The module SHALL have port stop_in, input, 1, a request to abort the run and return to IDLE.
REQ-010 The module SHALL have port throw_valid_out, output, 1, a one-cycle pulse marking a scheduled beat.
REQ-011 The module SHALL have port throw_ball_out, output, 3, the ID of the ball thrown.
REQ-012 The module SHALL have port throw_height_out, output, 3, the height thrown; 0 means an empty hand.
REQ-013 The module SHALL have port throw_hand_out, output, 1, the throwing hand: 0 is right, 1 is left.
REQ-014 The module SHALL have port running_out, output, 1, which is high in RUN.
REQ-015 The module SHALL have port error_out, output, 1, which is high in ERROR.

Function
REQ-016 The module SHALL implement the states IDLE, RUN and ERROR.
REQ-017 In IDLE, the module SHALL latch pattern_in, pattern_length and num_balls_in on the first cycle where pattern_valid_in=1 and pattern_length!=0; clear all 8 landing slots, beat counter t, pattern index, fresh-ball count and hand; and enter RUN on the next cycle.
REQ-018 The module SHALL ignore pattern_valid_in in RUN and ERROR; the latched pattern SHALL hold until the module returns to IDLE.
REQ-019 In RUN, on new_beat the module SHALL read h = pattern[idx] and slot s = t mod 8, and SHALL register the outputs one cycle later with a throw_valid_out pulse.
REQ-020 If slot s is occupied and h>0, the module SHALL throw the slot's ball: write it into slot (t+h) mod 8, then clear slot s.
REQ-021 If slot s is empty, h>0 and fresh<num_balls, the module SHALL inject ball ID=fresh, place it in slot (t+h) mod 8, and increment fresh.
REQ-022 If slot s is empty and h=0, the module SHALL output throw_ball_out=0 and throw_height_out=0 with no state change beyond advancing.
REQ-023 On every new_beat in RUN, the module SHALL advance t by one modulo 8; idx SHALL wrap to 0 after pattern_length-1; throw_hand_out SHALL toggle after each beat, starting at 0.
REQ-024 If stop_in and new_beat occur in the same cycle, stop_in SHALL win: the module enters IDLE, no throw is issued, and no pulse is produced.
REQ-025 new_beat in IDLE or ERROR SHALL produce no output pulse.
REQ-026 A beat SHALL never produce more than one throw_valid_out pulse; back-to-back new_beat cycles SHALL each be serviced, one pulse per beat in order.
REQ-027 The module SHALL leave ERROR only on stop_in or rst_in, and SHALL go to IDLE in either case.

Reset
REQ-028 When rst_in=1 on a clock edge, the module SHALL enter IDLE and clear all slots, t, idx, fresh and the latched pattern.
REQ-029 While rst_in=1, all outputs SHALL read 0; this SHALL hold even if reset is asserted mid-run.

Configuration
REQ-030 The module SHALL support the macro THROW_SCHED_CHECK_EN.
REQ-031 With THROW_SCHED_CHECK_EN defined, the module SHALL enter ERROR with no pulse on any of these conditions:
- the target slot is already occupied (collision);
- slot s is occupied and h=0 (a dropped ball);
- slot s is empty, h>0 and fresh=num_balls (no ball available).
REQ-032 Without THROW_SCHED_CHECK_EN, the module SHALL have no ERROR state and error_out SHALL be tied 0:
- a colliding write SHALL overwrite the slot;
- a dropped ball SHALL be discarded;
- a no-ball beat SHALL output height h with ball 0 and SHALL write no slot.

Verification
REQ-033 Pattern {3}, length 1, 3 balls, 6 beats -> balls 0,1,2,0,1,2, heights all 3, hands 0,1,0,1,0,1, error_out=0.
REQ-034 Pattern {5,0,1}, length 3, 2 balls, 9 beats -> ball/height sequence 0/5, -/0, 1/1, 1/5, -/0, 0/1, 0/5, -/0, 1/1.
REQ-035 Pattern {4,3}, length 2, 3 balls, with the check enabled -> a collision on beat 1 (target slot 4) sets error_out=1 with no pulse on beat 1; stop_in then returns the module to IDLE.
REQ-036 Run {3} and assert stop_in together with new_beat on beat 4 -> no pulse and running_out=0; a new pattern {4,4,1}, length 3, 3 balls, is then accepted.
REQ-037 Assert rst_in in RUN after beat 2 -> all outputs read 0 the next cycle; a following new_beat gives no pulse.
REQ-038 Change pattern_in during RUN with pattern_valid_in=1 -> the original sequence continues unchanged.
